dut_mac_pipe: RTL and testbench
===============================

DUT_MAC_PIPE -- requirements
Module: dut_mac_pipe

Interface
REQ-001 SHALL have parameter DIN0_WIDTH, default 12, multiplicand width.
REQ-002 SHALL have parameter DIN1_WIDTH, default 10, multiplier width.
REQ-003 SHALL have parameter DOUT_WIDTH, default 32, result and accumulator width.
REQ-004 SHALL have parameter NUM_STAGE, default 3, pipeline depth in cycles; legal range 1..8.
REQ-005 SHALL have parameter SIGNED, default 0; 0 means unsigned operands, 1 means two's-complement operands.
REQ-006 SHALL have port clk, input, 1 bit, the single clock; all state updates on the rising edge.
REQ-007 SHALL have port reset, input, 1 bit; asynchronous, active-high.
REQ-008 SHALL have port ce, input, 1 bit, global clock enable; low freezes all state.
REQ-009 SHALL have ports in_valid (input, 1 bit) and in_ready (output, 1 bit), the input handshake.
REQ-010 SHALL have ports din0 (input, DIN0_WIDTH) and din1 (input, DIN1_WIDTH), the operands.
REQ-011 SHALL have ports acc_first and acc_last, input, 1 bit each, the accumulation group markers.
REQ-012 SHALL have ports out_valid (output, 1 bit), out_ready (input, 1 bit) and dout (output, DOUT_WIDTH).
REQ-013 SHALL have port ovf, output, 1 bit, accumulation overflow flag qualified by out_valid.

Function
REQ-014 SHALL accept a beat when in_valid && in_ready.
REQ-015 SHALL drive in_ready = ce && (!out_valid || out_ready); the whole pipeline advances only on that condition, with no bubble collapsing.
REQ-016 SHALL compute the full DIN0_WIDTH+DIN1_WIDTH product, then extend it to DOUT_WIDTH (sign-extended if SIGNED=1, zero-extended otherwise) or truncate it to the low DOUT_WIDTH bits.
REQ-017 SHALL present an accepted beat's result on dout with out_valid high exactly NUM_STAGE advancing cycles after acceptance; a stall holds dout and out_valid stable.
REQ-018 SHALL carry a valid bit per stage so that empty slots never raise out_valid.
REQ-019 SHALL sustain a throughput of one beat per cycle while out_ready is held high.
REQ-020 SHALL hold dout, out_valid and ovf unchanged while ce is low, irrespective of the other inputs.

Reset
REQ-021 SHALL, on reset assertion, immediately clear every stage valid bit, out_valid, dout, the accumulator and ovf to 0, including mid-operation and mid-group; in-flight beats are discarded.
REQ-022 SHALL drive in_ready low while reset is high, and SHALL accept no beat in the first cycle after release unless ce is high.

Configuration
REQ-023 With DUT_MAC_ACC_EN defined, the final stage SHALL accumulate: on a beat with acc_first=1 the accumulator loads the product, otherwise it adds the product modulo 2^DOUT_WIDTH.
REQ-024 With DUT_MAC_ACC_EN defined, out_valid SHALL rise only for beats with acc_last=1, with dout equal to the group sum; acc_first=acc_last=1 gives a one-beat group.
REQ-025 With DUT_MAC_ACC_EN defined, ovf SHALL be set when any add in the group overflows (signed or unsigned per SIGNED), SHALL be sticky until the next acc_first, and SHALL be reported with the acc_last result.
REQ-026 Without DUT_MAC_ACC_EN, every beat SHALL produce an output, acc_first and acc_last SHALL be ignored, ovf SHALL be tied to 0, and no accumulator register SHALL exist.

Structure
REQ-027 Package dut_mac_pkg SHALL hold the stage-count limit constant, the extend-or-truncate width function and the typedef for the stage valid/marker bundle.
REQ-028 The multiply pipeline (operand registers plus NUM_STAGE-1 product registers, sharing one advance enable) SHALL be the sub-module dut_mac_pipe_mul; accumulation and the handshake logic stay at top level.

Verification
REQ-029 Unsigned, NUM_STAGE=3, no macro: beats 4095*1023, then 1*1, one per cycle with out_ready=1 -> dout=4189185 then 1 on consecutive cycles starting 3 cycles after the first accept.
REQ-030 SIGNED=1, DIN0=12, DIN1=10: din0=0xFFF (-1), din1=0x3FF (-1) -> dout=1; din0=0x800, din1=0x001 -> dout=0xFFFFF800.
REQ-031 Backpressure: out_ready low for 5 cycles while a result is valid -> in_ready low, dout stable, no beat lost or duplicated after release.
REQ-032 DUT_MAC_ACC_EN defined: group 2*3 (acc_first), 4*5, 6*7 (acc_last) -> single out_valid with dout=68; DOUT_WIDTH=8 with 255*255 plus 255*255 -> ovf=1.
REQ-033 Reset asserted asynchronously with 2 beats in flight and a group open -> out_valid=0 at once; after release the next group's sum excludes all prior beats.
REQ-034 ce low for 3 cycles mid-stream -> all outputs frozen; latency extends by exactly 3 cycles.

Source files
------------

// File: rtl/dut_mac_pkg.sv
// Shared types and helpers for the dut_mac_pipe multiply(-accumulate) pipeline.
// Accumulation is enabled by defining the DUT_MAC_ACC_EN macro.
package dut_mac_pkg;

  localparam int MAC_MAX_STAGE = 8;
  localparam int MAC_EXT_W     = 64;

  // Per-stage control bundle that travels alongside the product.
  typedef struct packed {
    logic vld;
    logic first;
    logic last;
  } mac_tag_t;

  // Treats the low src_w bits of v as the value and sign- or zero-extends it
  // to MAC_EXT_W bits. The caller truncates the result to its own width.
  function automatic logic [MAC_EXT_W-1:0] mac_ext(
    input logic [MAC_EXT_W-1:0] v,
    input int                   src_w,
    input logic                 sgn
  );
    logic [MAC_EXT_W-1:0] keep;
    logic [MAC_EXT_W-1:0] sh;
    logic                 msb;
    keep = (src_w >= MAC_EXT_W) ? '1 : ((64'd1 << src_w) - 64'd1);
    sh   = v >> (src_w - 1);
    msb  = sgn & sh[0];
    return (v & keep) | (msb ? ~keep : '0);
  endfunction

endpackage

// File: rtl/dut_mac_pipe_mul.sv
// Multiply pipeline: operand registers followed by product registers, all
// sharing one advance enable. ACC_TAP=1 drops the last register so that an
// external accumulator can act as the final stage.
module dut_mac_pipe_mul
  import dut_mac_pkg::*;
#(
  parameter int DIN0_WIDTH = 12,
  parameter int DIN1_WIDTH = 10,
  parameter int NUM_STAGE  = 3,
  parameter int SIGNED     = 0,
  parameter int ACC_TAP    = 0
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             adv_i,
  input  logic [DIN0_WIDTH-1:0]            din0_i,
  input  logic [DIN1_WIDTH-1:0]            din1_i,
  input  mac_tag_t                         tag_i,
  output logic [DIN0_WIDTH+DIN1_WIDTH-1:0] prod_o,
  output mac_tag_t                         tag_o
);

  localparam int PW   = DIN0_WIDTH + DIN1_WIDTH;
  localparam int NREG = NUM_STAGE - ACC_TAP;

  // Extending both operands to the full product width makes the low PW bits
  // of the plain product correct for either signedness.
  function automatic logic [PW-1:0] mul_full(
    input logic [DIN0_WIDTH-1:0] a,
    input logic [DIN1_WIDTH-1:0] b
  );
    logic [PW-1:0] ea;
    logic [PW-1:0] eb;
    ea = {{DIN1_WIDTH{(SIGNED != 0) & a[DIN0_WIDTH-1]}}, a};
    eb = {{DIN0_WIDTH{(SIGNED != 0) & b[DIN1_WIDTH-1]}}, b};
    return ea * eb;
  endfunction

  generate
    if (NREG == 0) begin : g_comb
      logic unused_ctl;
      assign unused_ctl = ^{clk_i, rst_i, adv_i};
      assign prod_o     = mul_full(din0_i, din1_i);
      assign tag_o      = tag_i;
    end else begin : g_reg
      logic [DIN0_WIDTH-1:0] a_q;
      logic [DIN1_WIDTH-1:0] b_q;
      mac_tag_t              tag1_q;
      logic [PW-1:0]         prod1;

      // stage 1: operand capture
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          a_q    <= '0;
          b_q    <= '0;
          tag1_q <= '0;
        end else if (adv_i) begin
          a_q    <= din0_i;
          b_q    <= din1_i;
          tag1_q <= tag_i;
        end
      end

      assign prod1 = mul_full(a_q, b_q);

      if (NREG == 1) begin : g_one
        assign prod_o = prod1;
        assign tag_o  = tag1_q;
      end else begin : g_deep
        logic [PW-1:0] prod_q [2:NREG];
        mac_tag_t      tag_q  [2:NREG];

        // stages 2..NREG: product delay line
        always_ff @(posedge clk_i or posedge rst_i) begin
          if (rst_i) begin
            for (int k = 2; k <= NREG; k++) begin
              prod_q[k] <= '0;
              tag_q[k]  <= '0;
            end
          end else if (adv_i) begin
            prod_q[2] <= prod1;
            tag_q[2]  <= tag1_q;
            for (int k = 3; k <= NREG; k++) begin
              prod_q[k] <= prod_q[k-1];
              tag_q[k]  <= tag_q[k-1];
            end
          end
        end

        assign prod_o = prod_q[NREG];
        assign tag_o  = tag_q[NREG];
      end
    end
  endgenerate

endmodule

// File: rtl/dut_mac_pipe.sv
// Pipelined multiplier with ready/valid handshake and clock enable.
// Defining DUT_MAC_ACC_EN turns the final stage into a group accumulator.
module dut_mac_pipe
  import dut_mac_pkg::*;
#(
  parameter int DIN0_WIDTH = 12,
  parameter int DIN1_WIDTH = 10,
  parameter int DOUT_WIDTH = 32,
  parameter int NUM_STAGE  = 3,
  parameter int SIGNED     = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  input  logic                  acc_first,
  input  logic                  acc_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  ovf
);

  localparam int PW  = DIN0_WIDTH + DIN1_WIDTH;
  localparam int STG = (NUM_STAGE > MAC_MAX_STAGE) ? MAC_MAX_STAGE :
                       (NUM_STAGE < 1) ? 1 : NUM_STAGE;
`ifdef DUT_MAC_ACC_EN
  localparam int ACC_TAP = 1;
`else
  localparam int ACC_TAP = 0;
`endif

  logic                  adv;
  mac_tag_t              tag_in;
  mac_tag_t              mul_tag;
  logic [PW-1:0]         mul_prod;
  logic [DOUT_WIDTH-1:0] prod_ext;

  // The whole pipeline moves in lock-step; no bubble collapsing.
  assign in_ready = !reset && ce && (!out_valid || out_ready);
  assign adv      = in_ready;

  always_comb begin
    tag_in       = '0;
    tag_in.vld   = in_valid;
    tag_in.first = acc_first;
    tag_in.last  = acc_last;
  end

  dut_mac_pipe_mul #(
    .DIN0_WIDTH (DIN0_WIDTH),
    .DIN1_WIDTH (DIN1_WIDTH),
    .NUM_STAGE  (STG),
    .SIGNED     (SIGNED),
    .ACC_TAP    (ACC_TAP)
  ) u_mul (
    .clk_i  (clk),
    .rst_i  (reset),
    .adv_i  (adv),
    .din0_i (din0),
    .din1_i (din1),
    .tag_i  (tag_in),
    .prod_o (mul_prod),
    .tag_o  (mul_tag)
  );

  assign prod_ext = DOUT_WIDTH'(mac_ext(MAC_EXT_W'(mul_prod), PW, SIGNED != 0));

`ifdef DUT_MAC_ACC_EN
  logic [DOUT_WIDTH-1:0] acc_q, acc_d;
  logic                  ovf_q, ovf_d;
  logic                  vld_q, vld_d;
  logic [DOUT_WIDTH:0]   usum;
  logic [DOUT_WIDTH-1:0] sum;
  logic                  add_ovf;
  logic                  loss;

  // A product that does not fit DOUT_WIDTH also makes the group sum wrong,
  // so it raises ovf together with genuine add overflow.
  assign loss = mac_ext(MAC_EXT_W'(mul_prod), PW, SIGNED != 0) !=
                mac_ext(MAC_EXT_W'(prod_ext), DOUT_WIDTH, SIGNED != 0);

  always_comb begin
    usum = {1'b0, acc_q} + {1'b0, prod_ext};
    sum  = usum[DOUT_WIDTH-1:0];
    if (SIGNED != 0) begin
      add_ovf = (acc_q[DOUT_WIDTH-1] == prod_ext[DOUT_WIDTH-1]) &&
                (sum[DOUT_WIDTH-1] != acc_q[DOUT_WIDTH-1]);
    end else begin
      add_ovf = usum[DOUT_WIDTH];
    end
    acc_d = acc_q;
    ovf_d = ovf_q;
    vld_d = vld_q;
    if (adv) begin
      vld_d = mul_tag.vld && mul_tag.last;
      if (mul_tag.vld) begin
        if (mul_tag.first) begin
          acc_d = prod_ext;
          ovf_d = loss;
        end else begin
          acc_d = sum;
          ovf_d = ovf_q | add_ovf | loss;
        end
      end
    end
  end

  // final stage: accumulator
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
      vld_q <= vld_d;
    end
  end

  assign out_valid = vld_q;
  assign dout      = acc_q;
  assign ovf       = ovf_q;
`else
  logic unused_markers;
  assign unused_markers = ^{mul_tag.first, mul_tag.last};
  assign out_valid      = mul_tag.vld;
  assign dout           = prod_ext;
  assign ovf            = 1'b0;
`endif

endmodule

// File: tb/tb_dut_mac_pipe.sv
// Randomized bench for dut_mac_pipe: three instances (unsigned/32, signed/32,
// unsigned/8) share one stimulus and are checked against an arithmetic model.
module tb_dut_mac_pipe;

  localparam int D0 = 12;
  localparam int D1 = 10;
  localparam int NS = 3;

  logic          clk = 1'b0;
  logic          reset, ce, in_valid, acc_first, acc_last, out_ready;
  logic [D0-1:0] din0;
  logic [D1-1:0] din1;
  logic          ir0, ir1, ir2, ov0, ov1, ov2, of0, of1, of2;
  logic [31:0]   do0, do1;
  logic [7:0]    do2;

  always #5 clk = ~clk;

  dut_mac_pipe #(.DIN0_WIDTH(D0), .DIN1_WIDTH(D1), .DOUT_WIDTH(32), .NUM_STAGE(NS), .SIGNED(0)) u_dut0 (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(ir0),
    .din0(din0), .din1(din1), .acc_first(acc_first), .acc_last(acc_last),
    .out_valid(ov0), .out_ready(out_ready), .dout(do0), .ovf(of0));

  dut_mac_pipe #(.DIN0_WIDTH(D0), .DIN1_WIDTH(D1), .DOUT_WIDTH(32), .NUM_STAGE(NS), .SIGNED(1)) u_dut1 (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(ir1),
    .din0(din0), .din1(din1), .acc_first(acc_first), .acc_last(acc_last),
    .out_valid(ov1), .out_ready(out_ready), .dout(do1), .ovf(of1));

  dut_mac_pipe #(.DIN0_WIDTH(D0), .DIN1_WIDTH(D1), .DOUT_WIDTH(8), .NUM_STAGE(NS), .SIGNED(0)) u_dut2 (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(ir2),
    .din0(din0), .din1(din1), .acc_first(acc_first), .acc_last(acc_last),
    .out_valid(ov2), .out_ready(out_ready), .dout(do2), .ovf(of2));

  typedef struct {
    logic [2:0][31:0] d;
    logic [2:0]       o;
    int               stamp;
  } exp_t;

  exp_t            expq[$];
  int              adv_cnt = 0;
  longint unsigned acc_m[3];
  bit              ovf_m[3];
  bit              accepted;
  int              checks = 0;
  int              errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ow(input int i);
    return (i == 2) ? 8 : 32;
  endfunction

  function automatic bit sg(input int i);
    return i == 1;
  endfunction

  function automatic longint sview(input longint unsigned v, input int w);
    if (v >= (64'd1 << (w - 1))) return longint'(v) - longint'(64'd1 << w);
    return longint'(v);
  endfunction

  function automatic longint prod_exact(input int i, input longint unsigned a, input longint unsigned b);
    longint sa, sb;
    sa = longint'(a);
    sb = longint'(b);
    if (sg(i)) begin
      sa = sview(a, D0);
      sb = sview(b, D1);
    end
    return sa * sb;
  endfunction

  // Applies one accepted beat to the model and queues any output it produces.
  task automatic model_accept();
    exp_t            e;
    bit              push;
    longint          p;
    longint unsigned pt, mk;
    int              w;
`ifdef DUT_MAC_ACC_EN
    bit              loss, aov;
    longint          s, lim;
`endif
    e.stamp = adv_cnt;
    push    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      w  = ow(i);
      mk = (64'd1 << w) - 64'd1;
      p  = prod_exact(i, 64'(din0), 64'(din1));
      pt = 64'(p) & mk;
`ifdef DUT_MAC_ACC_EN
      loss = sg(i) ? (sview(pt, w) != p) : (longint'(pt) != p);
      if (acc_first) begin
        acc_m[i] = pt;
        ovf_m[i] = loss;
      end else begin
        if (sg(i)) begin
          s   = sview(acc_m[i], w) + sview(pt, w);
          lim = longint'(64'd1 << (w - 1));
          aov = (s >= lim) || (s < -lim);
        end else begin
          aov = (acc_m[i] + pt) > mk;
        end
        acc_m[i] = (acc_m[i] + pt) & mk;
        ovf_m[i] = ovf_m[i] | loss | aov;
      end
      e.d[i] = 32'(acc_m[i]);
      e.o[i] = ovf_m[i];
`else
      e.d[i] = 32'(pt);
      e.o[i] = 1'b0;
`endif
    end
`ifdef DUT_MAC_ACC_EN
    push = acc_last;
`endif
    if (push) expq.push_back(e);
  endtask

  task automatic model_clear();
    expq.delete();
    for (int i = 0; i < 3; i++) begin
      acc_m[i] = 0;
      ovf_m[i] = 1'b0;
    end
  endtask

  // One clock: check at the falling edge, then let the rising edge happen.
  task automatic tick();
    bit exp_ov, exp_ir;
    @(negedge clk);
    exp_ov = (expq.size() > 0) && (expq[0].stamp + NS == adv_cnt);
    exp_ir = !reset && ce && (!exp_ov || out_ready);
    check_val("out_valid0", 64'(ov0), 64'(exp_ov));
    check_val("out_valid1", 64'(ov1), 64'(exp_ov));
    check_val("out_valid2", 64'(ov2), 64'(exp_ov));
    check_val("in_ready0", 64'(ir0), 64'(exp_ir));
    check_val("in_ready1", 64'(ir1), 64'(exp_ir));
    check_val("in_ready2", 64'(ir2), 64'(exp_ir));
    if (exp_ov) begin
      check_val("dout0", 64'(do0), 64'(expq[0].d[0]));
      check_val("dout1", 64'(do1), 64'(expq[0].d[1]));
      check_val("dout2", 64'(do2), 64'(expq[0].d[2][7:0]));
      check_val("ovf0", 64'(of0), 64'(expq[0].o[0]));
      check_val("ovf1", 64'(of1), 64'(expq[0].o[1]));
      check_val("ovf2", 64'(of2), 64'(expq[0].o[2]));
      if (exp_ir) void'(expq.pop_front());
    end
    accepted = 1'b0;
    if (exp_ir && in_valid) begin
      model_accept();
      accepted = 1'b1;
    end
    if (exp_ir) adv_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int a, input int b, input bit f, input bit l);
    int n;
    din0      = D0'(a);
    din1      = D1'(b);
    acc_first = f;
    acc_last  = l;
    in_valid  = 1'b1;
    n         = 0;
    accepted  = 1'b0;
    while (!accepted && n < 20) begin
      tick();
      n++;
    end
    check_val("send_accept", 64'(accepted), 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic check_cleared(input string tag);
    check_val({tag, "_ov0"}, 64'(ov0), 64'd0);
    check_val({tag, "_ov1"}, 64'(ov1), 64'd0);
    check_val({tag, "_ov2"}, 64'(ov2), 64'd0);
    check_val({tag, "_do0"}, 64'(do0), 64'd0);
    check_val({tag, "_do1"}, 64'(do1), 64'd0);
    check_val({tag, "_do2"}, 64'(do2), 64'd0);
    check_val({tag, "_ovf"}, 64'({of0, of1, of2}), 64'd0);
    check_val({tag, "_ir"}, 64'({ir0, ir1, ir2}), 64'd0);
  endtask

  task automatic rand_beat();
    din0      = D0'($urandom);
    din1      = D1'($urandom);
    acc_first = ($urandom_range(0, 3) == 0);
    acc_last  = ($urandom_range(0, 3) == 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; ce = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    din0 = '0; din1 = '0; acc_first = 1'b0; acc_last = 1'b0;
    model_clear();
    #3;
    check_cleared("reset");
    repeat (2) tick();
    reset = 1'b0;
    ce = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; ce = 1'b1;

    send(4095, 1023, 1'b1, 1'b1);
    send(1, 1, 1'b1, 1'b1);
    idle(5);
    send(12'hFFF, 10'h3FF, 1'b1, 1'b1);
    send(12'h800, 10'h001, 1'b1, 1'b1);
    idle(5);
    send(2, 3, 1'b1, 1'b0);
    send(4, 5, 1'b0, 1'b0);
    send(6, 7, 1'b0, 1'b1);
    idle(5);
    send(255, 255, 1'b1, 1'b0);
    send(255, 255, 1'b0, 1'b1);
    idle(5);

    for (int t = 0; t < 15; t++) begin
      in_valid = 1'b1;
      rand_beat();
      out_ready = !(t >= 4 && t < 9);
      tick();
    end
    out_ready = 1'b1;
    idle(5);

    for (int t = 0; t < 12; t++) begin
      in_valid = 1'b1;
      rand_beat();
      ce = !(t >= 5 && t < 8);
      tick();
    end
    ce = 1'b1;
    idle(5);

    in_valid = 1'b1; din0 = 12'd100; din1 = 10'd7; acc_first = 1'b1; acc_last = 1'b0;
    tick();
    acc_first = 1'b0;
    repeat (2) tick();
    #2;
    reset = 1'b1;
    #1;
    check_cleared("async_reset");
    model_clear();
    in_valid = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    send(3, 3, 1'b1, 1'b0);
    send(1, 1, 1'b0, 1'b1);
    idle(5);

    for (int t = 0; t < 400; t++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      rand_beat();
      ce        = ($urandom_range(0, 9) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    ce = 1'b1; out_ready = 1'b1;
    idle(10);
    check_val("drained", 64'(expq.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
